vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
 H_VISIBLE 800 active pixels per line; H_FRONT 40 front porch; H_SYNC 128 sync width; H_BACK 88 back porch
 V_VISIBLE 600 active lines; V_FRONT 1; V_SYNC 4; V_BACK 23
 SYNC_POL 1 asserted level of hsync/vsync (1 = positive)
 SETTLE_CYCLES 1024 stable-lock cycles required before scanning
REQ-002 SHALL have ports: name, direction, width, meaning (clock and reset first):
 clock  in  1  40 MHz pixel clock from the PLL clock_out
 reset_n  in  1  reset
 locked  in  1  PLL lock flag, asynchronous to clock
 hsync  out  1  horizontal sync
 vsync  out  1  vertical sync
 active  out  1  visible-pixel enable
 x  out  11  pixel column, valid when active
 y  out  10  pixel row, valid when active
 frame_start  out  1  one-cycle pulse at pixel (0,0)
 running  out  1  high while in RUN
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL synchronise locked through two flops on clock before any use (locked_s); 2-cycle latency.
REQ-005 SHALL implement states WAIT_LOCK, SETTLE, RUN.
REQ-006 WAIT_LOCK -> SETTLE when locked_s=1; settle counter cleared on entry.
REQ-007 SETTLE: counter increments each cycle locked_s=1; locked_s=0 -> WAIT_LOCK; counter reaching SETTLE_CYCLES-1 -> RUN.
REQ-008 RUN: locked_s=0 -> WAIT_LOCK next cycle; otherwise stay.
REQ-009 Counters h (11 b) and v (10 b) SHALL be 0 in all non-RUN states and on the first RUN cycle.
REQ-010 In RUN h SHALL increment each cycle, wrap H_TOTAL-1 (1055) -> 0; v SHALL increment only on h wrap, wrap V_TOTAL-1 (627) -> 0.
REQ-011 hsync = SYNC_POL when h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [840,967], else inverse.
REQ-012 vsync = SYNC_POL when v in [601,604], else inverse.
REQ-013 active = 1 when h<H_VISIBLE and v<V_VISIBLE; x=h, y=v when active, else x=0, y=0.
REQ-014 frame_start = 1 for the single cycle decoded from (h,v)=(0,0) in RUN.
REQ-015 All outputs SHALL be registered, exactly one clock after the counter value they decode.
REQ-016 Outside RUN (including the cycle after lock loss) outputs SHALL be idle: hsync=vsync=~SYNC_POL, active=0, x=0, y=0, frame_start=0, running=0.
REQ-017 running SHALL be 1 one cycle after state becomes RUN, 0 one cycle after leaving.
REQ-018 Lock glitch shorter than SETTLE_CYCLES SHALL restart the settle count from zero; no partial frame.

Reset
REQ-019 reset_n low SHALL immediately force state WAIT_LOCK, synchroniser flops 0, all counters 0, outputs to REQ-016 idle levels.
REQ-020 Release of reset_n SHALL take effect on the next clock edge; reset mid-frame discards the frame.

Structure
REQ-021 Timing defaults, H_TOTAL=1056, V_TOTAL=628, and the state encoding SHALL live in package vga_pkg.
REQ-022 The two-flop synchroniser SHALL be sub-module sync_bit (1-bit, async active-low reset).
REQ-023 Counter and comparator widths SHALL be derived from the totals; no truncation warnings.

Verification (bench SETTLE_CYCLES=16)
REQ-024 reset_n released, locked rises at cycle 0 -> running=1 at cycle 20 (2 sync + 1 WAIT + 16 SETTLE + 1 register), frame_start pulses the same cycle.
REQ-025 Free-run 2 frames -> hsync period 1056 cycles, width 128; vsync period 663168 cycles, width 4224; active count per frame 480000.
REQ-026 locked low for 5 cycles during SETTLE at count 10 -> no RUN; RUN only after 16 further consecutive locked cycles.
REQ-027 locked drops mid-frame at (h,v)=(500,300) -> within 4 cycles all outputs idle, running=0; re-lock restarts at (0,0) with frame_start.
REQ-028 reset_n pulsed low mid-line -> outputs idle asynchronously, no clock needed; sequence restarts per REQ-024.
REQ-029 Corner decode: (799,599) active=1 x=799 y=599; (800,599) and (0,600) active=0; h=840 hsync asserted; h=968 deasserted.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, derived counter widths and FSM encoding for the VGA
// sync generator (800x600 @ 60 Hz on a 40 MHz pixel clock).
package vga_pkg;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FRONT_DEF   = 40;
  localparam int H_SYNC_DEF    = 128;
  localparam int H_BACK_DEF    = 88;

  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FRONT_DEF   = 1;
  localparam int V_SYNC_DEF    = 4;
  localparam int V_BACK_DEF    = 23;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Number of bits needed to hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int H_CNT_W = cnt_width(H_TOTAL);
  localparam int V_CNT_W = cnt_width(V_TOTAL);

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE    = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN       = 2'd2;

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchroniser for a single asynchronous level into the clock domain.
module sync_bit (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: waits for a stable PLL lock, then scans h/v counters and
// emits registered sync, active-video, pixel coordinates and frame-start pulse.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE     = H_VISIBLE_DEF,
  parameter int H_FRONT       = H_FRONT_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BACK        = H_BACK_DEF,
  parameter int V_VISIBLE     = V_VISIBLE_DEF,
  parameter int V_FRONT       = V_FRONT_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BACK        = V_BACK_DEF,
  parameter int SYNC_POL      = 1,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               locked,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [H_CNT_W-1:0] x,
  output logic [V_CNT_W-1:0] y,
  output logic               frame_start,
  output logic               running
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int SET_W = cnt_width(SETTLE_CYCLES);

  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOT - 1);
  localparam logic [H_CNT_W-1:0] H_VIS      = H_CNT_W'(H_VISIBLE);
  localparam logic [H_CNT_W-1:0] H_SYNC_BEG = H_CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_CNT_W-1:0] H_SYNC_END = H_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOT - 1);
  localparam logic [V_CNT_W-1:0] V_VIS      = V_CNT_W'(V_VISIBLE);
  localparam logic [V_CNT_W-1:0] V_SYNC_BEG = V_CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_CNT_W-1:0] V_SYNC_END = V_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [SET_W-1:0]   SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
  localparam logic               SYNC_ON    = (SYNC_POL != 0);

  logic locked_s;

  logic [STATE_W-1:0] state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [H_CNT_W-1:0] h_q, h_d;
  logic [V_CNT_W-1:0] v_q, v_d;

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               active_q, active_d;
  logic [H_CNT_W-1:0] x_q, x_d;
  logic [V_CNT_W-1:0] y_q, y_d;
  logic               frame_start_q, frame_start_d;
  logic               running_q, running_d;

  sync_bit u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (locked),
    .q       (locked_s)
  );

  // Any drop of the synchronised lock sends us back to WAIT_LOCK, so a glitch
  // during SETTLE always restarts the stability count from zero.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        settle_d = '0;
        if (locked_s) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_d  = ST_WAIT_LOCK;
          settle_d = '0;
        end else if (settle_q == SET_LAST) begin
          state_d  = ST_RUN;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_RUN: begin
        settle_d = '0;
        if (!locked_s) state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d  = ST_WAIT_LOCK;
        settle_d = '0;
      end
    endcase
  end

  // Counters only advance while RUN persists, so the first RUN cycle sits at (0,0).
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + V_CNT_W'(1);
      end else begin
        h_d = h_q + H_CNT_W'(1);
        v_d = v_q;
      end
    end
  end

  always_comb begin
    hsync_d       = ~SYNC_ON;
    vsync_d       = ~SYNC_ON;
    active_d      = 1'b0;
    x_d           = '0;
    y_d           = '0;
    frame_start_d = 1'b0;
    running_d     = 1'b0;
    if (state_q == ST_RUN) begin
      running_d     = 1'b1;
      hsync_d       = (h_q >= H_SYNC_BEG && h_q <= H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
      vsync_d       = (v_q >= V_SYNC_BEG && v_q <= V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
      active_d      = (h_q < H_VIS) && (v_q < V_VIS);
      x_d           = active_d ? h_q : '0;
      y_d           = active_d ? v_q : '0;
      frame_start_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_WAIT_LOCK;
      settle_q      <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a scaled-down raster so whole
// frames fit in a short run; outputs are compared every cycle to a time-based model.
module tb_vga_sync_gen;

  localparam int HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int VV = 10, VF = 1, VS = 2, VB = 3;
  localparam int SET = 16;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int STARTUP = 20;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        locked;
  logic        hsync, vsync, active, frame_start, running;
  logic [10:0] x;
  logic [9:0]  y;

  int checks = 0;
  int errors = 0;
  int run_len = 0;
  bit hist0 = 1'b0, hist1 = 1'b0;
  int cyc = 0;

  always #5 clock = ~clock;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1), .SETTLE_CYCLES(SET)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .locked      (locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .running     (running)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expectIdle(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 0);
    check({tag, "_vsync"}, 32'(vsync), 0);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_running"}, 32'(running), 0);
  endtask

  // Model: RUN begins once locked has been seen (two cycles late) high for
  // SET+1 consecutive edges; outputs then show raster time t one cycle late.
  task automatic tick(input bit lk);
    int prev, t, h, v;
    bit s;
    locked = lk;
    @(posedge clock);
    #1;
    cyc++;
    if (!reset_n) begin
      run_len = 0;
      hist0 = 1'b0;
      hist1 = 1'b0;
      expectIdle("in_reset");
      return;
    end
    prev = run_len;
    s = hist0;
    hist0 = hist1;
    hist1 = lk;
    run_len = s ? run_len + 1 : 0;
    if (prev >= SET + 1) begin
      t = prev - (SET + 1);
      h = t % HT;
      v = (t / HT) % VT;
      check("hsync", 32'(hsync), 32'(h >= HV + HF && h <= HV + HF + HS - 1));
      check("vsync", 32'(vsync), 32'(v >= VV + VF && v <= VV + VF + VS - 1));
      check("active", 32'(active), 32'(h < HV && v < VV));
      check("x", 32'(x), (h < HV && v < VV) ? 32'(h) : 0);
      check("y", 32'(y), (h < HV && v < VV) ? 32'(v) : 0);
      check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
      check("running", 32'(running), 1);
    end else begin
      expectIdle("idle");
    end
  endtask

  task automatic applyReset(input bit lk);
    #2;
    reset_n = 1'b0;
    #1;
    expectIdle("async_reset");
    run_len = 0;
    hist0 = 1'b0;
    hist1 = 1'b0;
    tick(lk);
    tick(lk);
    reset_n = 1'b1;
  endtask

  task automatic measureStartup(input string tag);
    int n;
    n = 0;
    do begin
      tick(1'b1);
      n++;
    end while (!running && n < 3 * STARTUP);
    check({tag, "_latency"}, n, STARTUP);
    check({tag, "_frame_start"}, 32'(frame_start), 1);
  endtask

  initial begin
    int act_cnt, h_rise, h_fall, v_rise, n;
    bit h_prev, v_prev, found;

    reset_n = 1'b0;
    locked  = 1'b0;
    tick(1'b0);
    tick(1'b0);
    reset_n = 1'b1;
    tick(1'b0);
    tick(1'b0);

    $display("[TB] startup latency");
    measureStartup("startup");

    $display("[TB] free-run two frames");
    act_cnt = 32'(active);
    h_prev = hsync; v_prev = vsync;
    h_rise = -1; h_fall = -1; v_rise = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b1);
      if (frame_start) begin
        check("active_per_frame", act_cnt, HV * VV);
        act_cnt = 0;
      end
      act_cnt += 32'(active);
      if (hsync && !h_prev) begin
        if (h_rise >= 0) check("hsync_period", cyc - h_rise, HT);
        h_rise = cyc;
      end
      if (!hsync && h_prev && h_rise >= 0) check("hsync_width", cyc - h_rise, HS);
      if (vsync && !v_prev) begin
        if (v_rise >= 0) check("vsync_period", cyc - v_rise, FRAME);
        v_rise = cyc;
      end
      if (!vsync && v_prev && v_rise >= 0) check("vsync_width", cyc - v_rise, VS * HT);
      h_prev = hsync; v_prev = vsync;
    end

    $display("[TB] lock loss mid-frame");
    found = 1'b0;
    n = 0;
    while (!found && n < 2 * FRAME) begin
      tick(1'b1);
      n++;
      found = active && x == 11'd10 && y == 10'd5;
    end
    check("reach_mid_frame", 32'(found), 1);
    for (int i = 0; i < 4; i++) tick(1'b0);
    expectIdle("lock_loss");
    for (int i = 0; i < 4; i++) tick(1'b0);
    measureStartup("relock");

    $display("[TB] lock glitch during settle");
    for (int i = 0; i < 6; i++) tick(1'b0);
    for (int i = 0; i < 13; i++) tick(1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0);
    check("glitch_no_run", 32'(running), 0);
    measureStartup("after_glitch");

    $display("[TB] reset mid-line");
    for (int i = 0; i < 3 * HT + 7; i++) tick(1'b1);
    applyReset(1'b1);
    measureStartup("after_reset");

    $display("[TB] randomized lock activity");
    for (int r = 0; r < 40; r++) begin
      bit lv;
      int len;
      lv = ($urandom_range(0, 2) != 0);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(SET, FRAME + 40) : $urandom_range(1, 2 * SET + 4);
      for (int i = 0; i < len; i++) tick(lv);
      if ($urandom_range(0, 9) == 0) applyReset(lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
